noise_event_capture: RTL and testbench

NOISE_EVENT_CAPTURE -- requirements
Module: noise_event_capture

---
 rtl/noise_pkg.sv | 16 +
 rtl/noise_chan_sync.sv | 77 +++++++
 rtl/noise_event_capture.sv | 128 ++++++++++++
 tb/tb_noise_event_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared constants and read response type for noise_event_capture
package noise_pkg;

    // Width of the read channel selector; also bounds the channel count.
    localparam int SEL_W     = 5;
    localparam int MAX_CH    = 32;
    localparam int MAX_CNT_W = 16;

    // Registered read response; data is sized for the widest counter.
    typedef struct packed {
        logic [MAX_CNT_W-1:0] data;
        logic                 ovf;
        logic                 err;
    } rd_resp_t;

endpackage

// File: rtl/noise_chan_sync.sv
// rtl/noise_chan_sync.sv - one noise channel: edge toggle, synchronizer, strobe, optional holdoff (NOISE_HOLDOFF_EN)
module noise_chan_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_noise,
    input  logic i_en,
    output logic o_pulse
);

    logic                   r_tog;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pulse;
    logic                   w_evt;
    logic                   w_accept;

    // Each noise rising edge flips the toggle, so events survive being narrower than clk.
    always_ff @(posedge i_noise or posedge i_rst) begin
        if (i_rst) begin
            r_tog <= 1'b0;
        end else begin
            r_tog <= ~r_tog;
        end
    end

    // Bring the toggle into the clk domain; keeps tracking even while disabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], r_tog};
        end
    end

    // A change between the last two stages marks exactly one event.
    assign w_evt = r_sync[SYNC_STAGES-1] ^ r_sync[SYNC_STAGES-2];

`ifdef NOISE_HOLDOFF_EN
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    logic [HW-1:0] r_hold;

    assign w_accept = w_evt & i_en & (r_hold == '0);

    // Accepted events block further events for HOLDOFF cycles including their own.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= HW'(HOLD_LOAD);
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
        end
    end
`else
    // HOLDOFF has no effect in this build.
    logic [31:0] w_unused_holdoff;
    assign w_unused_holdoff = HOLDOFF;

    assign w_accept = w_evt & i_en;
`endif

    // Registered one-cycle event strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_accept;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/noise_event_capture.sv
// rtl/noise_event_capture.sv - multi-channel noise event counter with clear-on-read and irq (NOISE_HOLDOFF_EN)
module noise_event_capture
    import noise_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int HOLDOFF     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  noise_in,
    input  logic [N_CH-1:0]  en,
    output logic [N_CH-1:0]  pulse_out,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_ovf,
    output logic             rd_err,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  w_pulse;
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_ovf;
    rd_resp_t         r_resp;
    logic             r_ack;
    logic             r_irq;
    logic             w_sel_ok;
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_sel_ovf;
    logic             w_irq_next;
    logic             w_unused_resp;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        noise_chan_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .HOLDOFF    (HOLDOFF)
        ) u_chan (
            .i_clk  (clk),
            .i_rst  (reset),
            .i_noise(noise_in[g]),
            .i_en   (en[g]),
            .o_pulse(w_pulse[g])
        );
    end

    assign pulse_out = w_pulse;

    // Select the addressed channel and gather the interrupt condition.
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_cnt  = '0;
        w_sel_ovf  = 1'b0;
        w_irq_next = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_sel_ok  = 1'b1;
                w_sel_cnt = r_cnt[i];
                w_sel_ovf = r_ovf[i];
            end
            if (en[i] && (r_cnt[i] != '0)) begin
                w_irq_next = 1'b1;
            end
        end
    end

    // Saturating counters; a read clears, keeping an event that lands in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rd_req && (rd_sel == SEL_W'(i))) begin
                    r_cnt[i] <= w_pulse[i] ? CNT_W'(1) : '0;
                    r_ovf[i] <= 1'b0;
                end else if (w_pulse[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // One-cycle read response; pre-clear values of the addressed channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack  <= 1'b0;
            r_resp <= '0;
        end else begin
            r_ack <= rd_req;
            if (rd_req) begin
                r_resp.data <= MAX_CNT_W'(w_sel_cnt);
                r_resp.ovf  <= w_sel_ovf;
                r_resp.err  <= ~w_sel_ok;
            end else begin
                r_resp <= '0;
            end
        end
    end

    // Registered interrupt: any enabled channel holding events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_next;
        end
    end

    assign w_unused_resp = ^r_resp.data;

    assign rd_ack  = r_ack;
    assign rd_data = r_resp.data[CNT_W-1:0];
    assign rd_ovf  = r_resp.ovf;
    assign rd_err  = r_resp.err;
    assign irq     = r_irq;

endmodule

// File: tb/tb_noise_event_capture.sv
// tb/tb_noise_event_capture.sv - scoreboard bench for noise_event_capture (NOISE_HOLDOFF_EN aware)
module tb_noise_event_capture;

    localparam int N_CH    = 4;
    localparam int SYNC    = 2;
    localparam int CNT_W   = 8;
    localparam int HOLDOFF = 16;
`ifdef NOISE_HOLDOFF_EN
    localparam bit HO_EN = 1'b1;
`else
    localparam bit HO_EN = 1'b0;
`endif
    localparam int GAP  = HO_EN ? HOLDOFF + 4 : 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [N_CH-1:0]  noise_in;
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  pulse_out;
    logic             rd_req;
    logic [4:0]       rd_sel;
    logic             rd_ack;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             rd_err;
    logic             irq;

    noise_event_capture #(
        .N_CH       (N_CH),
        .SYNC_STAGES(SYNC),
        .CNT_W      (CNT_W),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .noise_in (noise_in),
        .en       (en),
        .pulse_out(pulse_out),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_ovf   (rd_ovf),
        .rd_err   (rd_err),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: total accepted events per channel since last read.
    int mdl_ev [N_CH];
    int pulse_cnt [N_CH];

    typedef struct {
        int data;
        int ovf;
        int err;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_x;

    // Events at t = i*sp; an event counts if holdoff is off or HOLDOFF cycles passed since the last counted one.
    function automatic int holdoff_accept(input int n, input int sp);
        int c    = 0;
        int last = -1000000;
        for (int i = 0; i < n; i++) begin
            if (!HO_EN || (i * sp - last >= HOLDOFF)) begin
                c++;
                last = i * sp;
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fire(input logic [N_CH-1:0] m);
        noise_in = m;
        tick();
        noise_in = '0;
    endtask

    task automatic do_read(input int sel, input int d, input int o, input int e);
        exp_t x;
        x.data = d;
        x.ovf  = o;
        x.err  = e;
        x.cyc  = cyc + 1;
        exp_q.push_back(x);
        rd_req = 1'b1;
        rd_sel = 5'(sel);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic mdl_read(input int sel);
        if (sel < N_CH) begin
            do_read(sel, (mdl_ev[sel] > CMAX) ? CMAX : mdl_ev[sel], int'(mdl_ev[sel] > CMAX), 0);
            mdl_ev[sel] = 0;
        end else begin
            do_read(sel, 0, 0, 1);
        end
    endtask

    // Monitor: count strobes and check every read response against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (pulse_out[i]) pulse_cnt[i]++;
        end
        if (rd_ack) begin
            if (exp_q.size() == 0) begin
                check("rd_ack_unexpected", int'(rd_ack), 0);
            end else begin
                mon_x = exp_q.pop_front();
                check("rd_ack_cycle", cyc, mon_x.cyc);
                check("rd_data", int'(rd_data), mon_x.data);
                check("rd_ovf", int'(rd_ovf), mon_x.ovf);
                check("rd_err", int'(rd_err), mon_x.err);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_x = exp_q.pop_front();
            check("rd_ack_missing", int'(rd_ack), 1);
        end
    end

    initial begin
        int k;
        int base [N_CH];
        int exp_p [N_CH];
        logic [N_CH-1:0] e;
        logic [N_CH-1:0] f;
        int exp_irq;

        reset    = 1'b0;
        noise_in = '0;
        en       = '0;
        rd_req   = 1'b0;
        rd_sel   = '0;
        #1 reset = 1'b1;
        repeat (3) tick();
        check("reset_pulse_out", int'(pulse_out), 0);
        check("reset_rd_ack", int'(rd_ack), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_rd_ovf", int'(rd_ovf), 0);
        check("reset_rd_err", int'(rd_err), 0);
        check("reset_irq", int'(irq), 0);
        reset = 1'b0;
        en    = '1;
        repeat (2) tick();

        // Single edge on ch0: strobe exactly at the SYNC-th edge.
        k = cyc;
        fire(4'b0001);
        for (int j = 0; j < 4; j++) begin
            check("single_edge_pulse0", int'(pulse_out[0]), int'(cyc == k + SYNC));
            tick();
        end
        mdl_ev[0] += 1;
        mdl_read(0);
        tick();

        // Reset while an event is in the synchronizer: no strobe afterwards.
        fire(4'b0001);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < N_CH; i++) mdl_ev[i] = 0;
        for (int j = 0; j < 6; j++) begin
            check("reset_midop_no_pulse", int'(pulse_out), 0);
            tick();
        end
        fire(4'b0001);
        repeat (4) tick();
        mdl_ev[0] += 1;
        mdl_read(0);
        tick();

        // 300 edges on ch1 spaced 3 clk: saturation and sticky ovf, then clear-on-read.
        for (int j = 0; j < 300; j++) begin
            fire(4'b0010);
            repeat (2) tick();
        end
        repeat (4) tick();
        mdl_ev[1] += holdoff_accept(300, 3);
        mdl_read(1);
        mdl_read(1);
        tick();

        // ch2 disabled during edges, then enabled: no strobes, no count.
        en = 4'b1011;
        tick();
        base[2] = pulse_cnt[2];
        for (int j = 0; j < 5; j++) begin
            fire(4'b0100);
            repeat (GAP) tick();
        end
        check("disabled_no_pulse", pulse_cnt[2] - base[2], 0);
        en = '1;
        repeat (6) tick();
        check("enable_no_spurious", pulse_cnt[2] - base[2], 0);
        mdl_read(2);
        tick();

        // Read ch3 in the same cycle as its strobe with count 4.
        for (int j = 0; j < 4; j++) begin
            fire(4'b1000);
            repeat (GAP) tick();
        end
        fire(4'b1000);
        repeat (SYNC - 1) tick();
        check("same_cycle_pulse3", int'(pulse_out[3]), 1);
        do_read(3, 4, 0, 0);
        do_read(3, 1, 0, 0);
        mdl_ev[3] = 0;
        repeat (2) tick();

        // Out-of-range selectors.
        mdl_read(N_CH);
        mdl_read(31);
        tick();

        // Edges every 4 clk for 40 clk on ch0.
        repeat (GAP) tick();
        for (int j = 0; j < 10; j++) begin
            fire(4'b0001);
            repeat (3) tick();
        end
        repeat (6) tick();
        mdl_ev[0] += holdoff_accept(10, 4);
        mdl_read(0);
        repeat (GAP) tick();

        // Randomized rounds: random enables and edge sets, irq and reads against the model.
        for (int i = 0; i < N_CH; i++) begin
            base[i]  = pulse_cnt[i];
            exp_p[i] = 0;
        end
        for (int r = 0; r < 40; r++) begin
            e  = N_CH'($urandom);
            f  = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            en = e;
            tick();
            fire(f);
            for (int i = 0; i < N_CH; i++) begin
                if (f[i] && e[i]) begin
                    mdl_ev[i]++;
                    exp_p[i]++;
                end
            end
            repeat (GAP) tick();
            exp_irq = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (e[i] && mdl_ev[i] != 0) exp_irq = 1;
            end
            check("rand_irq", int'(irq), exp_irq);
            if ($urandom_range(0, 1) == 1) mdl_read(int'($urandom_range(0, N_CH)));
        end
        repeat (4) tick();
        for (int i = 0; i < N_CH; i++) begin
            check("rand_pulse_count", pulse_cnt[i] - base[i], exp_p[i]);
        end
        for (int i = 0; i < N_CH; i++) mdl_read(i);
        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
